fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter PARITY, default 0, meaning 0=none, 1=even, 2=odd; value 3 SHALL be rejected at elaboration.
REQ-002 Parameter STOP_BITS, default 1, meaning number of stop bits (1 or 2); other values SHALL be rejected at elaboration.
REQ-003 clk_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_in  input  1  synchronous, active-low reset.
REQ-005 baudDiv_in  input  16  bit period minus one, in clk_in cycles.
REQ-006 data_in  input  8  byte offered by upstream FIFO consumer port.
REQ-007 valid_in  input  1  upstream has a byte on data_in.
REQ-008 ready_out  output  1  block accepts data_in on this edge when valid_in=1.
REQ-009 tx_out  output  1  serial line, idle high.
REQ-010 busy_out  output  1  high while a frame is on the line.
REQ-011 sentCount_out  output  16  count of fully transmitted frames.

Function
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY=0.
REQ-013 A byte SHALL be accepted on an edge where valid_in=1 and ready_out=1; data_in and baudDiv_in SHALL be latched on that edge.
REQ-014 ready_out SHALL be 1 in IDLE and in the last cycle of the final stop bit, 0 otherwise, and 0 while reset_in=0.
REQ-015 The cycle after acceptance, tx_out SHALL be 0 (START); zero-latency start, no idle gap between back-to-back frames.
REQ-016 Each bit SHALL last exactly latched baudDiv+1 cycles; baudDiv=0 gives 1-cycle bits; changes to baudDiv_in mid-frame SHALL have no effect.
REQ-017 Data bits SHALL be sent LSB first, 8 bits.
REQ-018 Parity bit SHALL be XOR of data bits (even) or its inverse (odd).
REQ-019 STOP SHALL drive tx_out=1 for STOP_BITS bit periods.
REQ-020 Frame length SHALL be (1+8+(PARITY!=0)+STOP_BITS)*(baudDiv+1) cycles.
REQ-021 busy_out SHALL be 1 from the first START cycle through the last STOP cycle inclusive.
REQ-022 sentCount_out SHALL increment by 1 on the edge ending the final stop bit; it SHALL wrap 0xFFFF->0x0000.
REQ-023 If valid_in=0 at end of STOP, the block SHALL enter IDLE with tx_out=1.
REQ-024 tx_out SHALL be driven from a register (glitch-free).

Reset
REQ-025 While reset_in=0 at an edge: state=IDLE, tx_out=1, busy_out=0, sentCount_out=0x0000, bit and period counters=0.
REQ-026 Reset mid-frame SHALL abort the frame without incrementing sentCount_out; tx_out SHALL be 1 from the next edge.
REQ-027 The first byte SHALL be acceptable on the first edge after reset_in returns to 1.

Structure
REQ-028 Package fifo_uart_pkg SHALL hold the state enum, PARITY encodings (NONE/EVEN/ODD) and bit-count constants.
REQ-029 One sub-module, uart_bit_timer, SHALL hold the period counter: loads the latched divisor, emits a one-cycle tick at period end.
REQ-030 No other hierarchy; the top-level instantiation SHALL connect data_in/valid_in/ready_out directly to the write FIFO consumer port.

Verification
REQ-031 PARITY=0, STOP_BITS=1, baudDiv=3, send 0xA5 -> tx_out 0,1,0,1,0,0,1,0,1,1 each 4 cycles, 40 cycles total, ready_out low 39 cycles, sentCount_out=1.
REQ-032 PARITY=1, baudDiv=0, send 0xA5 then 0x01 back-to-back -> parity bits 0 then 1, no idle cycle between frames, 22 cycles total, sentCount_out=2.
REQ-033 PARITY=2, STOP_BITS=2, baudDiv=1, send 0x00 -> parity bit 1, stop high 4 cycles, 24-cycle frame.
REQ-034 baudDiv_in changed 3->9 mid-frame -> current frame keeps 4-cycle bits; next accepted frame uses 10-cycle bits.
REQ-035 reset_in=0 during DATA bit 3 -> tx_out=1, busy_out=0, ready_out=0 next edge, sentCount_out=0; new byte accepted on the first edge after release.
REQ-036 Preload sentCount_out=0xFFFF via 65535 frames at baudDiv=0, send one more -> sentCount_out=0x0000.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = 3;
  localparam int DIV_W     = 16;
  localparam int CNT_W     = 16;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: ticks on the last cycle of each bit and reloads itself.
module uart_bit_timer
  import fifo_uart_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // tick must not depend on load_i: load is derived from ready, which uses tick
  assign tick_o = run_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || tick_o) begin
      cnt_d = div_i;
    end else if (run_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter pulling bytes from a FIFO consumer port, back-to-back capable.
// state     | meaning
// ST_IDLE   | line high, waiting for a byte
// ST_START  | start bit (low)
// ST_DATA   | eight data bits, LSB first
// ST_PARITY | parity bit (never entered when PARITY is none)
// ST_STOP   | STOP_BITS stop periods (high); may accept the next byte
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [DIV_W-1:0] baudDiv_in,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             tx_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] sentCount_out
);

  if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
    $error("fifo_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_e              state_q;
  logic [DATA_BITS-1:0]   data_q;
  logic [DIV_W-1:0]       div_q;
  logic [BIT_IDX_W-1:0]   bit_idx_q;
  logic                   stop_idx_q;
  logic                   par_q;
  logic                   tx_q;
  logic                   busy_q;
  logic [CNT_W-1:0]       sent_q;

  logic tick;
  logic last_stop;
  logic ready;
  logic accept;

  assign last_stop = (state_q == ST_STOP) && tick && (stop_idx_q == 1'(STOP_BITS - 1));
  assign ready     = reset_in && ((state_q == ST_IDLE) || last_stop);
  assign accept    = valid_in && ready;

  uart_bit_timer u_bit_timer (
    .clk_i  (clk_in),
    .rst_ni (reset_in),
    .load_i (accept),
    .run_i  (state_q != ST_IDLE),
    .div_i  (accept ? baudDiv_in : div_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      sent_q     <= '0;
    end else begin
      if (accept) begin
        data_q <= data_in;
        div_q  <= baudDiv_in;
        par_q  <= parity_bit(data_in, PARITY);
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state_q   <= ST_DATA;
            tx_q      <= data_q[0];
            bit_idx_q <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
              bit_idx_q <= '0;
              if (PARITY != PARITY_NONE) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q    <= ST_STOP;
                tx_q       <= 1'b1;
                stop_idx_q <= 1'b0;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= data_q[bit_idx_q + 1'b1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q    <= ST_STOP;
            tx_q       <= 1'b1;
            stop_idx_q <= 1'b0;
          end
        end
        ST_STOP: begin
          if (last_stop) begin
            sent_q     <= sent_q + 1'b1;
            stop_idx_q <= 1'b0;
            if (accept) begin
              state_q <= ST_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else if (tick) begin
            stop_idx_q <= stop_idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out     = ready;
  assign tx_out        = tx_q;
  assign busy_out      = busy_q;
  assign sentCount_out = sent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Three transmitter configurations; a per-cycle line scoreboard plus directed handshake and counter checks.
module tb_fifo_uart_tx;

  logic        clk;
  logic [2:0]  rst_n;
  logic [2:0]  valid;
  logic [2:0]  ready;
  logic [2:0]  tx;
  logic [2:0]  busy;
  logic [7:0]  data [3];
  logic [15:0] div  [3];
  logic [15:0] sent [3];

  int checks   = 0;
  int failures = 0;

  int par_cfg  [3] = '{0, 1, 2};
  int stop_cfg [3] = '{1, 1, 2};

  bit q0[$];
  bit q1[$];
  bit q2[$];

  fifo_uart_tx #(.PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk_in(clk), .reset_in(rst_n[0]), .baudDiv_in(div[0]), .data_in(data[0]),
    .valid_in(valid[0]), .ready_out(ready[0]), .tx_out(tx[0]), .busy_out(busy[0]),
    .sentCount_out(sent[0]));

  fifo_uart_tx #(.PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk_in(clk), .reset_in(rst_n[1]), .baudDiv_in(div[1]), .data_in(data[1]),
    .valid_in(valid[1]), .ready_out(ready[1]), .tx_out(tx[1]), .busy_out(busy[1]),
    .sentCount_out(sent[1]));

  fifo_uart_tx #(.PARITY(2), .STOP_BITS(2)) u_dut2 (
    .clk_in(clk), .reset_in(rst_n[2]), .baudDiv_in(div[2]), .data_in(data[2]),
    .valid_in(valid[2]), .ready_out(ready[2]), .tx_out(tx[2]), .busy_out(busy[2]),
    .sentCount_out(sent[2]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic bit q_pop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void q_push(input int i, input bit b);
    case (i)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endfunction

  function automatic void q_flush(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Expected line level for every cycle of one frame
  function automatic void push_frame(input int i, input logic [7:0] b, input logic [15:0] d);
    bit bits[$];
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
    if (par_cfg[i] != 0) bits.push_back((^b) ^ (par_cfg[i] == 2));
    for (int k = 0; k < stop_cfg[i]; k++) bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c <= int'(d); c++) q_push(i, bits[k]);
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (q_size(i) > 0) begin
        chk($sformatf("tx%0d", i), {31'd0, tx[i]}, {31'd0, q_pop(i)});
        chk($sformatf("busy%0d", i), {31'd0, busy[i]}, 32'd1);
      end else begin
        chk($sformatf("tx_idle%0d", i), {31'd0, tx[i]}, 32'd1);
        chk($sformatf("busy_idle%0d", i), {31'd0, busy[i]}, 32'd0);
      end
    end
  end

  // Offer a byte; waited = cycles spent with ready low before acceptance
  task automatic send(input int i, input logic [7:0] b, input logic [15:0] d,
                      input bit rel, output int waited);
    @(negedge clk);
    if (rel) rst_n[i] = 1'b1;
    data[i]  = b;
    div[i]   = d;
    valid[i] = 1'b1;
    waited   = 0;
    #1;
    while (!ready[i] && waited < 2000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk($sformatf("ready_wait%0d", i), {31'd0, ready[i]}, 32'd1);
    if (ready[i]) begin
      @(posedge clk);
      push_frame(i, b, d);
    end
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (q_size(i) != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    chk($sformatf("done_busy%0d", i), {31'd0, busy[i]}, 32'd0);
    chk($sformatf("done_ready%0d", i), {31'd0, ready[i]}, 32'd1);
  endtask

  initial begin
    int w;
    clk   = 1'b0;
    rst_n = 3'b000;
    valid = 3'b000;
    for (int i = 0; i < 3; i++) begin
      data[i] = 8'h00;
      div[i]  = 16'd0;
    end

    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready%0d", i), {31'd0, ready[i]}, 32'd0);
      chk($sformatf("rst_tx%0d", i), {31'd0, tx[i]}, 32'd1);
      chk($sformatf("rst_busy%0d", i), {31'd0, busy[i]}, 32'd0);
      chk($sformatf("rst_sent%0d", i), {16'd0, sent[i]}, 32'd0);
    end

    // Single 0xA5 frame, 4-cycle bits, accepted on first edge after reset
    send(0, 8'hA5, 16'd3, 1'b1, w);
    chk("first_accept0", w, 32'd0);
    idle(0);
    wait_done(0);
    chk("sent_a5", {16'd0, sent[0]}, 32'd1);

    // Back-to-back; divisor changes 3->9 during the first frame
    send(0, 8'h3C, 16'd3, 1'b0, w);
    send(0, 8'h5A, 16'd9, 1'b0, w);
    chk("ready_low0", w, 32'd39);
    idle(0);
    wait_done(0);
    chk("sent_div", {16'd0, sent[0]}, 32'd3);

    // Reset during data bit 3
    send(0, 8'h96, 16'd3, 1'b0, w);
    idle(0);
    repeat (17) @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    chk("ready_in_rst", {31'd0, ready[0]}, 32'd0);
    @(posedge clk);
    q_flush(0);
    @(negedge clk);
    #1;
    chk("abort_tx", {31'd0, tx[0]}, 32'd1);
    chk("abort_busy", {31'd0, busy[0]}, 32'd0);
    chk("abort_ready", {31'd0, ready[0]}, 32'd0);
    chk("abort_sent", {16'd0, sent[0]}, 32'd0);
    send(0, 8'h81, 16'd0, 1'b1, w);
    chk("post_rst_accept", w, 32'd0);
    idle(0);
    wait_done(0);
    chk("sent_after_rst", {16'd0, sent[0]}, 32'd1);

    // Counter wrap from 0xFFFF
    @(negedge clk);
    force u_dut0.sent_q = 16'hFFFF;
    @(negedge clk);
    release u_dut0.sent_q;
    send(0, 8'h42, 16'd0, 1'b0, w);
    idle(0);
    wait_done(0);
    chk("sent_wrap", {16'd0, sent[0]}, 32'd0);

    // Even parity, 1-cycle bits, back-to-back 0xA5 then 0x01
    send(1, 8'hA5, 16'd0, 1'b1, w);
    chk("first_accept1", w, 32'd0);
    send(1, 8'h01, 16'd0, 1'b0, w);
    chk("ready_low1", w, 32'd10);
    idle(1);
    wait_done(1);
    chk("sent_even", {16'd0, sent[1]}, 32'd2);

    // Odd parity, two stop bits, 2-cycle bits
    send(2, 8'h00, 16'd1, 1'b1, w);
    chk("first_accept2", w, 32'd0);
    send(2, 8'h0F, 16'd1, 1'b0, w);
    chk("ready_low2", w, 32'd23);
    idle(2);
    wait_done(2);
    chk("sent_odd", {16'd0, sent[2]}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
